// File: rtl/fb_pkg.sv
// Shared codes, types and default widths for the feedback LUT port-B scheduler.
package fb_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 7;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        LUT_B1I = 2'd0,
        LUT_B1Q = 2'd1,
        LUT_B2I = 2'd2,
        LUT_B2Q = 2'd3
    } lut_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PEND      = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_WAIT = 3'd3,
        ST_CLEAR     = 3'd4
    } state_e;

    function automatic logic [3:0] lut_onehot(input lut_e lut);
        logic [3:0] oh;
        case (lut)
            LUT_B1I: oh = 4'b0001;
            LUT_B1Q: oh = 4'b0010;
            LUT_B2I: oh = 4'b0100;
            LUT_B2Q: oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/fb_lut_write_sched_if.sv
// Host request / readback handshake between the register interface and the LUT scheduler.
interface fb_lut_write_sched_if
    import fb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [1:0]    req_lut;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    modport master (
        output req_valid, req_op, req_lut, req_addr, req_data,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_op, req_lut, req_addr, req_data,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/fb_holdoff_guard.sv
// Turns the beam store window into a holdoff that stays asserted for GUARD
// cycles after store_strb falls.
module fb_holdoff_guard #(
    parameter int GUARD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic store_strb,
    output logic holdoff
);
    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
    localparam logic [GW-1:0] GUARD_LD = GW'(GUARD);

    logic [GW-1:0] guard_cnt_r;

    // Guard counter: reload while the store window is open, then count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guard_cnt_r <= {GW{1'b0}};
        end else if (store_strb) begin
            guard_cnt_r <= GUARD_LD;
        end else if (guard_cnt_r != {GW{1'b0}}) begin
            guard_cnt_r <= guard_cnt_r - GW'(1'b1);
        end else begin
            guard_cnt_r <= {GW{1'b0}};
        end
    end

    assign holdoff = store_strb | (guard_cnt_r != {GW{1'b0}});

endmodule

// File: rtl/fb_lut_write_sched.sv
// Sequences host write/read/clear requests onto the shared port-B bus of the four
// feedback gain LUTs, never touching them while the beam store holdoff is active.
module fb_lut_write_sched
    import fb_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = 2,
    parameter int GUARD  = 4,
    parameter int CW     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 store_strb,
    fb_lut_write_sched_if.slave  bus,
    output logic [AW-1:0]        bpm_lut_addrb,
    output logic [DW-1:0]        bpm_lut_dinb,
    output logic                 bpm1_i_lut_web,
    output logic                 bpm1_q_lut_web,
    output logic                 bpm2_i_lut_web,
    output logic                 bpm2_q_lut_web,
    input  logic [DW-1:0]        bpm1_i_lut_doutb,
    input  logic [DW-1:0]        bpm1_q_lut_doutb,
    input  logic [DW-1:0]        bpm2_i_lut_doutb,
    input  logic [DW-1:0]        bpm2_q_lut_doutb,
    output logic                 busy,
    output logic [CW-1:0]        deferred_cnt
);
    localparam int RCW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [RCW-1:0] RD_LAST = RCW'(RD_LAT);
    localparam logic [AW-1:0]  ADDR_MAX = {AW{1'b1}};
    localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

    logic holdoff_s;

    state_e         state_r,    state_nxt;
    op_e            op_r,       op_nxt;
    lut_e           lut_r,      lut_nxt;
    logic [AW-1:0]  addr_r,     addr_nxt;
    logic [DW-1:0]  data_r,     data_nxt;
    logic [AW-1:0]  clr_addr_r, clr_addr_nxt;
    logic           clr_done_r, clr_done_nxt;
    logic [RCW-1:0] rd_cnt_r,   rd_cnt_nxt;

    logic           req_ready_r;
    logic           busy_r;
    logic [AW-1:0]  addrb_r,    addrb_nxt;
    logic [DW-1:0]  dinb_r,     dinb_nxt;
    logic [3:0]     web_r,      web_nxt;
    logic           rd_valid_r, rd_valid_nxt;
    logic [DW-1:0]  rd_data_r,  rd_data_nxt;
    logic [CW-1:0]  deferred_r, deferred_nxt;
    logic [DW-1:0]  sel_dout_s;

    fb_holdoff_guard #(
        .GUARD (GUARD)
    ) u_guard (
        .clk        (clk),
        .rst_n      (rst_n),
        .store_strb (store_strb),
        .holdoff    (holdoff_s)
    );

    // Readback mux for the LUT addressed by the latched request.
    always_comb begin
        sel_dout_s = {DW{1'b0}};
        case (lut_r)
            LUT_B1I: sel_dout_s = bpm1_i_lut_doutb;
            LUT_B1Q: sel_dout_s = bpm1_q_lut_doutb;
            LUT_B2I: sel_dout_s = bpm2_i_lut_doutb;
            LUT_B2Q: sel_dout_s = bpm2_q_lut_doutb;
            default: sel_dout_s = {DW{1'b0}};
        endcase
    end

    // Next-state and next-output logic; outputs are registered from these values
    // so that a web decision always uses the holdoff sampled at the same edge.
    always_comb begin
        state_nxt    = state_r;
        op_nxt       = op_r;
        lut_nxt      = lut_r;
        addr_nxt     = addr_r;
        data_nxt     = data_r;
        clr_addr_nxt = clr_addr_r;
        clr_done_nxt = clr_done_r;
        rd_cnt_nxt   = rd_cnt_r;
        addrb_nxt    = addrb_r;
        dinb_nxt     = dinb_r;
        web_nxt      = 4'b0000;
        rd_valid_nxt = 1'b0;
        rd_data_nxt  = rd_data_r;
        deferred_nxt = deferred_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    op_nxt    = op_e'(bus.req_op);
                    lut_nxt   = lut_e'(bus.req_lut);
                    addr_nxt  = bus.req_addr;
                    data_nxt  = bus.req_data;
                    state_nxt = ST_PEND;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (op_r == OP_RSVD) begin
                    state_nxt = ST_IDLE;
                end else if (holdoff_s) begin
                    if (deferred_r != CNT_MAX) begin
                        deferred_nxt = deferred_r + CW'(1'b1);
                    end else begin
                        deferred_nxt = deferred_r;
                    end
                end else begin
                    case (op_r)
                        OP_WRITE: begin
                            state_nxt = ST_WRITE;
                            web_nxt   = lut_onehot(lut_r);
                            addrb_nxt = addr_r;
                            dinb_nxt  = data_r;
                        end
                        OP_READ: begin
                            state_nxt  = ST_READ_WAIT;
                            addrb_nxt  = addr_r;
                            rd_cnt_nxt = {RCW{1'b0}};
                        end
                        OP_CLEAR: begin
                            state_nxt    = ST_CLEAR;
                            web_nxt      = lut_onehot(lut_r);
                            addrb_nxt    = {AW{1'b0}};
                            dinb_nxt     = data_r;
                            clr_addr_nxt = AW'(1'b1);
                            clr_done_nxt = (ADDR_MAX == {AW{1'b0}});
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WRITE: begin
                state_nxt = ST_IDLE;
            end
            ST_READ_WAIT: begin
                // Holdoff is deliberately ignored here: a read cannot disturb the LUTs.
                if (rd_cnt_r == RD_LAST) begin
                    rd_data_nxt  = sel_dout_s;
                    rd_valid_nxt = 1'b1;
                    state_nxt    = ST_IDLE;
                end else begin
                    rd_cnt_nxt = rd_cnt_r + RCW'(1'b1);
                end
            end
            ST_CLEAR: begin
                if (clr_done_r) begin
                    state_nxt = ST_IDLE;
                end else if (holdoff_s) begin
                    state_nxt = ST_CLEAR;
                end else begin
                    web_nxt      = lut_onehot(lut_r);
                    addrb_nxt    = clr_addr_r;
                    dinb_nxt     = data_r;
                    clr_addr_nxt = clr_addr_r + AW'(1'b1);
                    clr_done_nxt = (clr_addr_r == ADDR_MAX);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, request latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_WRITE;
            lut_r       <= LUT_B1I;
            addr_r      <= {AW{1'b0}};
            data_r      <= {DW{1'b0}};
            clr_addr_r  <= {AW{1'b0}};
            clr_done_r  <= 1'b0;
            rd_cnt_r    <= {RCW{1'b0}};
            req_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            addrb_r     <= {AW{1'b0}};
            dinb_r      <= {DW{1'b0}};
            web_r       <= 4'b0000;
            rd_valid_r  <= 1'b0;
            rd_data_r   <= {DW{1'b0}};
            deferred_r  <= {CW{1'b0}};
        end else begin
            state_r     <= state_nxt;
            op_r        <= op_nxt;
            lut_r       <= lut_nxt;
            addr_r      <= addr_nxt;
            data_r      <= data_nxt;
            clr_addr_r  <= clr_addr_nxt;
            clr_done_r  <= clr_done_nxt;
            rd_cnt_r    <= rd_cnt_nxt;
            req_ready_r <= (state_nxt == ST_IDLE);
            busy_r      <= (state_nxt != ST_IDLE);
            addrb_r     <= addrb_nxt;
            dinb_r      <= dinb_nxt;
            web_r       <= web_nxt;
            rd_valid_r  <= rd_valid_nxt;
            rd_data_r   <= rd_data_nxt;
            deferred_r  <= deferred_nxt;
        end
    end

    assign bus.req_ready     = req_ready_r;
    assign bus.rd_valid      = rd_valid_r;
    assign bus.rd_data       = rd_data_r;
    assign bpm_lut_addrb     = addrb_r;
    assign bpm_lut_dinb      = dinb_r;
    assign bpm1_i_lut_web    = web_r[0];
    assign bpm1_q_lut_web    = web_r[1];
    assign bpm2_i_lut_web    = web_r[2];
    assign bpm2_q_lut_web    = web_r[3];
    assign busy              = busy_r;
    assign deferred_cnt      = deferred_r;

endmodule

// File: tb/tb_fb_lut_write_sched.sv
// Self-checking bench: full-width instance for write/read/holdoff vectors and an
// AW=4 instance for whole-table clear, clear interruption and reset mid-clear.
module tb_fb_lut_write_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b, strb_a, strb_b;

    fb_lut_write_sched_if #(.AW(15), .DW(7)) if_a ();
    fb_lut_write_sched_if #(.AW(4),  .DW(7)) if_b ();

    logic [14:0] addrb_a;
    logic [6:0]  dinb_a;
    logic [3:0]  web_a;
    logic        busy_a;
    logic [15:0] def_a;
    logic [14:0] a_s1, a_q;
    logic [6:0]  d_b1i, d_b1q, d_b2i, d_b2q;

    logic [3:0]  addrb_b;
    logic [6:0]  dinb_b;
    logic [3:0]  web_b;
    logic        busy_b;
    logic [15:0] def_b;
    logic [6:0]  d_zero;

    assign d_zero = 7'h00;

    // LUT port-B model: address register plus output register (two-cycle latency).
    always @(posedge clk) begin
        a_s1 <= addrb_a;
        a_q  <= a_s1;
    end
    assign d_b1i = a_q[6:0] ^ 7'h01;
    assign d_b1q = a_q[6:0];
    assign d_b2i = a_q[6:0] ^ 7'h40;
    assign d_b2q = ~a_q[6:0];

    fb_lut_write_sched #(.AW(15), .DW(7), .RD_LAT(2), .GUARD(4), .CW(16)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .store_strb(strb_a), .bus(if_a),
        .bpm_lut_addrb(addrb_a), .bpm_lut_dinb(dinb_a),
        .bpm1_i_lut_web(web_a[0]), .bpm1_q_lut_web(web_a[1]),
        .bpm2_i_lut_web(web_a[2]), .bpm2_q_lut_web(web_a[3]),
        .bpm1_i_lut_doutb(d_b1i), .bpm1_q_lut_doutb(d_b1q),
        .bpm2_i_lut_doutb(d_b2i), .bpm2_q_lut_doutb(d_b2q),
        .busy(busy_a), .deferred_cnt(def_a)
    );

    fb_lut_write_sched #(.AW(4), .DW(7), .RD_LAT(2), .GUARD(4), .CW(16)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .store_strb(strb_b), .bus(if_b),
        .bpm_lut_addrb(addrb_b), .bpm_lut_dinb(dinb_b),
        .bpm1_i_lut_web(web_b[0]), .bpm1_q_lut_web(web_b[1]),
        .bpm2_i_lut_web(web_b[2]), .bpm2_q_lut_web(web_b[3]),
        .bpm1_i_lut_doutb(d_zero), .bpm1_q_lut_doutb(d_zero),
        .bpm2_i_lut_doutb(d_zero), .bpm2_q_lut_doutb(d_zero),
        .busy(busy_b), .deferred_cnt(def_b)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  lut;
        logic [14:0] addr;
        logic [6:0]  data;
        logic [3:0]  exp_web;
        int          exp_wcnt;
        int          exp_rcnt;
        logic [6:0]  exp_rd;
        logic [14:0] exp_addrb;
        logic [6:0]  exp_dinb;
        int          exp_lat;
    } vec_t;

    vec_t vecs [8];
    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic wait_ready_b();
        int k = 0;
        while (!if_b.req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_b", 0, {31'd0, if_b.req_ready}, 32'd1);
    endtask

    // Issues a clear of bpm1_q with fill 0x3 on the AW=4 instance and logs its web cycles.
    task automatic run_clear(input int pulse_at, input int rst_at,
                             output int wcnt, output int bad, output int viol, output int multi,
                             output int c5, output int c6, output int cfirst, output int clast,
                             output int rst_hit);
        int g = 0;
        int scnt = 0;
        logic hold;
        wcnt = 0; bad = 0; viol = 0; multi = 0;
        c5 = -1; c6 = -1; cfirst = -1; clast = -1; rst_hit = 0;
        wait_ready_b();
        if_b.req_valid = 1'b1; if_b.req_op = 2'b10; if_b.req_lut = 2'd1;
        if_b.req_addr = 4'h0; if_b.req_data = 7'h03;
        @(negedge clk);
        if_b.req_valid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            hold = strb_b || (g != 0);
            g = strb_b ? 4 : ((g > 0) ? g - 1 : 0);
            if (scnt > 0) begin
                scnt--;
                if (scnt == 0) strb_b = 1'b0;
            end
            if (web_b != 4'b0000) begin
                if (web_b != 4'b0010) bad++;
                if ($countones(web_b) > 1) multi++;
                if (hold) viol++;
                if (addrb_b != wcnt[3:0]) bad++;
                if (dinb_b != 7'h03) bad++;
                if (cfirst < 0) cfirst = c;
                clast = c;
                if (addrb_b == 4'd5) c5 = c;
                if (addrb_b == 4'd6) c6 = c;
                wcnt++;
                if (pulse_at >= 0 && int'(addrb_b) == pulse_at) begin
                    strb_b = 1'b1;
                    scnt = 3;
                end
                if (rst_at >= 0 && int'(addrb_b) == rst_at) begin
                    rst_n_b = 1'b0;
                    #1;
                    rst_hit = 1;
                    break;
                end
            end
        end
    endtask

    initial begin
        int wcnt, rcnt, lat, bad, viol, multi, c5, c6, cf, cl, rh;
        logic [3:0] wor_s;

        vecs[0] = '{2'b00, 2'd2, 15'h1234, 7'h55, 4'b0100, 1, 0, 7'h00, 15'h1234, 7'h55, 1};
        vecs[1] = '{2'b01, 2'd1, 15'h007F, 7'h00, 4'b0000, 0, 1, 7'h7F, 15'h007F, 7'h55, 4};
        vecs[2] = '{2'b00, 2'd0, 15'h0001, 7'h7F, 4'b0001, 1, 0, 7'h7F, 15'h0001, 7'h7F, 1};
        vecs[3] = '{2'b01, 2'd0, 15'h0123, 7'h00, 4'b0000, 0, 1, 7'h22, 15'h0123, 7'h7F, 4};
        vecs[4] = '{2'b00, 2'd3, 15'h7FFF, 7'h2A, 4'b1000, 1, 0, 7'h22, 15'h7FFF, 7'h2A, 1};
        vecs[5] = '{2'b01, 2'd3, 15'h0055, 7'h00, 4'b0000, 0, 1, 7'h2A, 15'h0055, 7'h2A, 4};
        vecs[6] = '{2'b01, 2'd2, 15'h0005, 7'h00, 4'b0000, 0, 1, 7'h45, 15'h0005, 7'h2A, 4};
        vecs[7] = '{2'b11, 2'd1, 15'h0100, 7'h11, 4'b0000, 0, 0, 7'h45, 15'h0005, 7'h2A, -1};

        rst_n_a = 1'b0; rst_n_b = 1'b0; strb_a = 1'b0; strb_b = 1'b0;
        if_a.req_valid = 1'b0; if_a.req_op = 2'b00; if_a.req_lut = 2'd0;
        if_a.req_addr = 15'h0; if_a.req_data = 7'h0;
        if_b.req_valid = 1'b0; if_b.req_op = 2'b00; if_b.req_lut = 2'd0;
        if_b.req_addr = 4'h0; if_b.req_data = 7'h0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 0, {31'd0, if_a.req_ready}, 32'd0);
        chk("rst_busy", 0, {31'd0, busy_a}, 32'd0);
        chk("rst_web", 0, {28'd0, web_a}, 32'd0);
        chk("rst_addrb", 0, {17'd0, addrb_a}, 32'd0);
        chk("rst_rdvalid", 0, {31'd0, if_a.rd_valid}, 32'd0);
        chk("rst_deferred", 0, {16'd0, def_a}, 32'd0);
        rst_n_a = 1'b1; rst_n_b = 1'b1;
        #1;
        chk("ready_before_edge", 0, {31'd0, if_a.req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 0, {31'd0, if_a.req_ready}, 32'd1);

        // Table-driven single write/read/reserved requests on the full-width instance.
        for (int i = 0; i < 8; i++) begin
            if_a.req_valid = 1'b1; if_a.req_op = vecs[i].op; if_a.req_lut = vecs[i].lut;
            if_a.req_addr = vecs[i].addr; if_a.req_data = vecs[i].data;
            @(negedge clk);
            if_a.req_valid = 1'b0;
            chk("busy_pend", i, {31'd0, busy_a}, 32'd1);
            wcnt = 0; rcnt = 0; lat = -1; wor_s = 4'b0000;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (web_a != 4'b0000) begin
                    wcnt++;
                    wor_s = wor_s | web_a;
                    if (lat < 0) lat = c;
                end
                if (if_a.rd_valid) begin
                    rcnt++;
                    if (lat < 0) lat = c;
                end
            end
            chk("web_sel", i, {28'd0, wor_s}, {28'd0, vecs[i].exp_web});
            chk("web_cnt", i, wcnt, vecs[i].exp_wcnt);
            chk("rd_cnt", i, rcnt, vecs[i].exp_rcnt);
            chk("rd_data", i, {25'd0, if_a.rd_data}, {25'd0, vecs[i].exp_rd});
            chk("addrb", i, {17'd0, addrb_a}, {17'd0, vecs[i].exp_addrb});
            chk("dinb", i, {25'd0, dinb_a}, {25'd0, vecs[i].exp_dinb});
            chk("latency", i, lat, vecs[i].exp_lat);
            chk("busy_done", i, {31'd0, busy_a}, 32'd0);
            chk("ready_done", i, {31'd0, if_a.req_ready}, 32'd1);
        end
        chk("deferred_idle", 0, {16'd0, def_a}, 32'd0);

        // Write issued inside a 10-cycle store window: web only after the guard expires.
        strb_a = 1'b1;
        repeat (2) @(negedge clk);
        if_a.req_valid = 1'b1; if_a.req_op = 2'b00; if_a.req_lut = 2'd0;
        if_a.req_addr = 15'h0ABC; if_a.req_data = 7'h5A;
        @(negedge clk);
        if_a.req_valid = 1'b0;
        wcnt = 0; lat = -1; wor_s = 4'b0000;
        for (int k = 4; k <= 24; k++) begin
            @(negedge clk);
            if (web_a != 4'b0000) begin
                wcnt++;
                wor_s = wor_s | web_a;
                if (lat < 0) lat = k;
            end
            if (k == 10) strb_a = 1'b0;
        end
        chk("defer_first_web", 0, lat, 15);
        chk("defer_web_cnt", 0, wcnt, 1);
        chk("defer_web_sel", 0, {28'd0, wor_s}, 32'h1);
        chk("defer_cnt", 0, {16'd0, def_a}, 32'd11);
        chk("defer_addrb", 0, {17'd0, addrb_a}, 32'h0ABC);
        chk("defer_dinb", 0, {25'd0, dinb_a}, 32'h5A);

        // Uninterrupted whole-table clear.
        run_clear(-1, -1, wcnt, bad, viol, multi, c5, c6, cf, cl, rh);
        chk("clr_web_cnt", 0, wcnt, 16);
        chk("clr_seq_err", 0, bad, 0);
        chk("clr_span", 0, cl - cf, 15);
        chk("clr_multi_hot", 0, multi, 0);
        chk("clr_busy_end", 0, {31'd0, busy_b}, 32'd0);

        // Clear interrupted by a 3-cycle store pulse after address 5.
        run_clear(5, -1, wcnt, bad, viol, multi, c5, c6, cf, cl, rh);
        chk("clri_web_cnt", 1, wcnt, 16);
        chk("clri_seq_err", 1, bad, 0);
        chk("clri_gap_5_6", 1, c6 - c5, 8);
        chk("clri_span", 1, cl - cf, 22);
        chk("clri_holdoff_web", 1, viol, 0);
        chk("clri_multi_hot", 1, multi, 0);
        chk("clri_busy_end", 1, {31'd0, busy_b}, 32'd0);

        // Reset asserted in the cycle address 9 is written.
        run_clear(-1, 9, wcnt, bad, viol, multi, c5, c6, cf, cl, rh);
        chk("rstc_hit", 2, rh, 1);
        chk("rstc_web", 2, {28'd0, web_b}, 32'd0);
        chk("rstc_addrb", 2, {28'd0, addrb_b}, 32'd0);
        chk("rstc_dinb", 2, {25'd0, dinb_b}, 32'd0);
        chk("rstc_busy", 2, {31'd0, busy_b}, 32'd0);
        chk("rstc_ready", 2, {31'd0, if_b.req_ready}, 32'd0);
        @(negedge clk);
        rst_n_b = 1'b1;
        wcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (web_b != 4'b0000) wcnt++;
        end
        chk("rstc_no_resume", 2, wcnt, 0);
        wait_ready_b();
        if_b.req_valid = 1'b1; if_b.req_op = 2'b00; if_b.req_lut = 2'd3;
        if_b.req_addr = 4'hA; if_b.req_data = 7'h11;
        @(negedge clk);
        if_b.req_valid = 1'b0;
        wcnt = 0; lat = -1; wor_s = 4'b0000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (web_b != 4'b0000) begin
                wcnt++;
                wor_s = wor_s | web_b;
                if (lat < 0) lat = c;
                chk("post_rst_addrb", 3, {28'd0, addrb_b}, 32'hA);
                chk("post_rst_dinb", 3, {25'd0, dinb_b}, 32'h11);
            end
        end
        chk("post_rst_web_cnt", 3, wcnt, 1);
        chk("post_rst_web_sel", 3, {28'd0, wor_s}, 32'h8);
        chk("post_rst_latency", 3, lat, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
